bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
- 4-digit BCD up/down event counter with a built-in time-scan multiplexer.
- Sits directly upstream of the team's 4-bit-to-7-segment decoder: each scan slot drives one digit code into the decoder and one active-low digit-select line.
- Codes 10–15 blank the decoder; code 4'hF is the blank code used for leading-zero suppression.

Parameters:
- TICK_DIV, 100000000: count-enable prescaler period in clk cycles (>=1); one count step per period.
- SCAN_DIV, 100000: clk cycles each digit stays selected (>=1).
- BLANK_LZ, 1: 1 = suppress leading zeros on digits 3..1; 0 = always show all digits.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; prescaler advances only while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  16  four BCD digits; [3:0] = digit 0 (units).
- count  out  16  current BCD value, registered.
- wrap  out  1  one-cycle pulse when the count wraps.
- digit_code  out  4  code for the decoder; bit 3 has weight 8; 4'hF = blank.
- digit_sel  out  4  one-hot active-low digit enable; bit i low selects digit i.

Behaviour:
- Reset, async while rst_n=0:
  - count=0, prescaler=0, wrap=0.
  - scan index=0, scan timer=0.
  - digit_sel=4'b1110, digit_code=4'h0.
- Priority per cycle: clear > load > tick. All take effect on the next rising edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and holds while en=0.
  - tick is asserted in the cycle the prescaler equals TICK_DIV-1 with en=1; the prescaler returns to 0 on the following edge.
  - clear or load forces the prescaler to 0.
- Count step on tick:
  - Up: digit0+1. A digit at 9 becomes 0 and carries into the next digit.
  - Down: digit0-1. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap:
  - 9999 up -> 0000, or 0000 down -> 9999; wrap=1 for exactly the cycle after that edge.
  - wrap=0 otherwise, including after clear and load.
- Load: each load_val digit >9 is stored as 9; valid digits are stored unchanged.
- Scan:
  - The scan timer counts 0..SCAN_DIV-1. At SCAN_DIV-1 the index advances 0->1->2->3->0.
  - The scan runs continuously, independent of en, clear and load; only rst_n resets it.
- Display outputs:
  - digit_sel and digit_code are registered together and update on the same edge, so they are never misaligned.
  - digit_code is taken from the count value registered on that same edge; a count change appears at the outputs at most one cycle later.
  - With SCAN_DIV=1 the index advances every cycle.
- Leading-zero blanking (BLANK_LZ=1):
  - digit i (i=3..1) outputs 4'hF when it and all higher digits are 0.
  - digit 0 is never blanked, so value 0 shows "0".
- Simultaneous events:
  - tick coincident with clear/load is discarded, with no wrap.
  - Direction change takes effect on the next tick.
- Reset mid-operation: all state returns to reset values immediately, without waiting for clk.

Test Plan:
- Reset/idle: rst_n=0 then 1, en=0, TICK_DIV=4, SCAN_DIV=2 -> count=0x0000 held.
  - digit_sel cycles 1110,1101,1011,0111, changing every 2 clk.
  - digit_code=0 on digit0 and F on digits 1–3 (BLANK_LZ=1).
- Up carry: load 0x0099, en=1, up=1, TICK_DIV=4 -> count steps every 4 clk.
  - 0x0099 -> 0x0100; wrap stays 0.
- Wrap both ways:
  - load 0x9999, up=1 -> 0x0000 after one tick, wrap=1 for exactly 1 clk.
  - then up=0 -> 0x9999 after one tick, wrap pulses again.
- Priority/saturation:
  - load_val=0x3AF2 -> count=0x3992.
  - clear and load together with a tick pending -> count=0x0000, prescaler=0, no wrap.
  - en=0 mid-period -> prescaler holds and resumes from the same value.
- Blanking: BLANK_LZ=1, count=0x0405 -> codes F,4,0,5 on digits 3..0; BLANK_LZ=0, count=0x0005 -> codes 0,0,0,5.
- Async reset mid-count: assert rst_n low between clk edges at count=0x1234 -> count=0 and digit_sel=1110 immediately, before the next clk edge.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down event counter with a prescaled count enable and a
// time-multiplexed digit scanner that feeds a 7-segment decoder.
module bcd_scan_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  digit_code,
  output logic [3:0]  digit_sel
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Returns {wrap, next value}; the final carry/borrow out of digit 3 is the wrap.
  function automatic logic [16:0] bcd_step(input logic [15:0] val, input logic dir);
    logic [15:0] res;
    logic [3:0]  d;
    logic        carry;
    carry = 1'b1;
    res   = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = val[i*4 +: 4];
      if (!carry) begin
        d = d;
      end else if (dir) begin
        if (d == 4'd9) begin
          d     = 4'd0;
          carry = 1'b1;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        if (d == 4'd0) begin
          d     = 4'd9;
          carry = 1'b1;
        end else begin
          d     = d - 4'd1;
          carry = 1'b0;
        end
      end
      res[i*4 +: 4] = d;
    end
    return {carry, res};
  endfunction

  function automatic logic [15:0] bcd_sat(input logic [15:0] val);
    logic [15:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*4 +: 4] = (val[i*4 +: 4] > 4'd9) ? 4'd9 : val[i*4 +: 4];
    end
    return res;
  endfunction

  // Digit i>0 is blanked when it and every more significant digit are zero.
  function automatic logic [3:0] digit_of(input logic [15:0] val, input logic [1:0] idx);
    logic [3:0] code;
    case (idx)
      2'd0:    code = val[3:0];
      2'd1:    code = (BLANK_LZ && (val[15:4]  == 12'h000)) ? 4'hF : val[7:4];
      2'd2:    code = (BLANK_LZ && (val[15:8]  == 8'h00))   ? 4'hF : val[11:8];
      2'd3:    code = (BLANK_LZ && (val[15:12] == 4'h0))    ? 4'hF : val[15:12];
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  logic [PW-1:0] presc_r, presc_nx_s;
  logic [SW-1:0] scan_tmr_r, scan_tmr_nx_s;
  logic [1:0]    scan_idx_r, scan_idx_nx_s;
  logic [15:0]   count_nx_s;
  logic [16:0]   step_s;
  logic          wrap_nx_s;
  logic          tick_s;

  // Count/prescaler next state with clear > load > tick priority.
  always_comb begin
    count_nx_s = count;
    presc_nx_s = presc_r;
    wrap_nx_s  = 1'b0;
    step_s     = bcd_step(count, up);
    tick_s     = en && (presc_r == PW'(TICK_DIV - 1));
    if (clear) begin
      count_nx_s = 16'h0000;
      presc_nx_s = {PW{1'b0}};
    end else if (load) begin
      count_nx_s = bcd_sat(load_val);
      presc_nx_s = {PW{1'b0}};
    end else if (tick_s) begin
      count_nx_s = step_s[15:0];
      wrap_nx_s  = step_s[16];
      presc_nx_s = {PW{1'b0}};
    end else if (en) begin
      presc_nx_s = presc_r + PW'(1);
    end else begin
      presc_nx_s = presc_r;
    end
  end

  // Free-running scan timer and digit index.
  always_comb begin
    scan_tmr_nx_s = scan_tmr_r + SW'(1);
    scan_idx_nx_s = scan_idx_r;
    if (scan_tmr_r == SW'(SCAN_DIV - 1)) begin
      scan_tmr_nx_s = {SW{1'b0}};
      scan_idx_nx_s = scan_idx_r + 2'd1;
    end else begin
      scan_idx_nx_s = scan_idx_r;
    end
  end

  // State and output registers; display uses the same-edge count so code and select stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r    <= {PW{1'b0}};
      count      <= 16'h0000;
      wrap       <= 1'b0;
      scan_tmr_r <= {SW{1'b0}};
      scan_idx_r <= 2'd0;
      digit_sel  <= 4'b1110;
      digit_code <= 4'h0;
    end else begin
      presc_r    <= presc_nx_s;
      count      <= count_nx_s;
      wrap       <= wrap_nx_s;
      scan_tmr_r <= scan_tmr_nx_s;
      scan_idx_r <= scan_idx_nx_s;
      digit_sel  <= ~(4'b0001 << scan_idx_nx_s);
      digit_code <= digit_of(count_nx_s, scan_idx_nx_s);
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: table of load vectors, hand-written
// corner sequences and random traffic against an integer-arithmetic reference model.
module tb_bcd_scan_counter;

  localparam int TD   = 4;
  localparam int SD_A = 2;
  localparam int SD_B = 1;

  logic        clk = 1'b0;
  logic        rst_n, en, up, clear, load;
  logic [15:0] load_val;
  logic [15:0] count_a, count_b;
  logic        wrap_a, wrap_b;
  logic [3:0]  code_a, code_b, sel_a, sel_b;

  bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD_A), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_a), .wrap(wrap_a),
    .digit_code(code_a), .digit_sel(sel_a));

  bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD_B), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_b), .wrap(wrap_b),
    .digit_code(code_b), .digit_sel(sel_b));

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mv, mp, mn;   // model value 0..9999, prescaler, edges since reset
  logic mw;

  typedef struct {
    logic [15:0] lv;
    logic [15:0] exp_cnt;
    logic [15:0] exp_codes;     // {d3,d2,d1,d0} with leading-zero blanking
    logic [15:0] exp_codes_nb;  // without blanking
  } vec_t;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_val(input logic [15:0] lv);
    int s = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      s = s * 10 + d;
    end
    return s;
  endfunction

  function automatic logic [3:0] exp_code(input int v, input int idx, input bit blz);
    int p = 1;
    repeat (idx) p = p * 10;
    if (blz && idx > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int ia, ib;
    logic [3:0] one;
    one = 4'b0001;
    ia  = (mn / SD_A) % 4;
    ib  = (mn / SD_B) % 4;
    chk("count_a", count_a, to_bcd(mv));
    chk("count_b", count_b, to_bcd(mv));
    chk("wrap_a", {15'd0, wrap_a}, {15'd0, mw});
    chk("wrap_b", {15'd0, wrap_b}, {15'd0, mw});
    chk("sel_a", {12'd0, sel_a}, {12'd0, ~(one << ia)});
    chk("sel_b", {12'd0, sel_b}, {12'd0, ~(one << ib)});
    chk("code_a", {12'd0, code_a}, {12'd0, exp_code(mv, ia, 1'b1)});
    chk("code_b", {12'd0, code_b}, {12'd0, exp_code(mv, ib, 1'b0)});
  endtask

  // Advance the model with the current inputs, then let the DUT take the edge and compare.
  task automatic cyc();
    if (clear) begin
      mv = 0; mp = 0; mw = 1'b0;
    end else if (load) begin
      mv = sat_val(load_val); mp = 0; mw = 1'b0;
    end else if (en && mp == TD - 1) begin
      mp = 0;
      if (up) begin
        mw = (mv == 9999); mv = (mv + 1) % 10000;
      end else begin
        mw = (mv == 0); mv = (mv + 9999) % 10000;
      end
    end else begin
      if (en) mp++;
      mw = 1'b0;
    end
    mn++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h3AF2, 16'h3992, 16'h3992, 16'h3992};
    vecs[1] = '{16'h0405, 16'h0405, 16'hF405, 16'h0405};
    vecs[2] = '{16'h0005, 16'h0005, 16'hFFF5, 16'h0005};
    vecs[3] = '{16'hFFFF, 16'h9999, 16'h9999, 16'h9999};
    vecs[4] = '{16'hA0B0, 16'h9090, 16'h9090, 16'h9090};
    vecs[5] = '{16'h0000, 16'h0000, 16'hFFF0, 16'h0000};
    vecs[6] = '{16'h0070, 16'h0070, 16'hFF70, 16'h0070};

    rst_n = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 16'h0000;
    mv = 0; mp = 0; mn = 0; mw = 1'b0;
    #12;
    chk("reset_count", count_a, 16'h0000);
    chk("reset_sel", {12'd0, sel_a}, 16'h000E);
    chk("reset_code", {12'd0, code_a}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan with en=0: count held, digits rotate.
    repeat (10) cyc();

    // Load/saturation/blanking table.
    for (int v = 0; v < 7; v++) begin
      en = 1'b0;
      do_load(vecs[v].lv);
      chk("tbl_count", count_a, vecs[v].exp_cnt);
      repeat (8) begin
        cyc();
        for (int i = 0; i < 4; i++) begin
          if (sel_a[i] == 1'b0) chk("tbl_code_a", {12'd0, code_a}, {12'd0, vecs[v].exp_codes[i*4 +: 4]});
          if (sel_b[i] == 1'b0) chk("tbl_code_b", {12'd0, code_b}, {12'd0, vecs[v].exp_codes_nb[i*4 +: 4]});
        end
      end
    end

    // Up carry 0099 -> 0100.
    en = 1'b1; up = 1'b1;
    do_load(16'h0099);
    repeat (3) cyc();
    chk("carry_hold", count_a, 16'h0099);
    cyc();
    chk("carry_count", count_a, 16'h0100);
    chk("carry_wrap", {15'd0, wrap_a}, 16'h0000);

    // Wrap up then down.
    do_load(16'h9999);
    repeat (4) cyc();
    chk("wrap_up_cnt", count_a, 16'h0000);
    chk("wrap_up_pulse", {15'd0, wrap_a}, 16'h0001);
    up = 1'b0;
    cyc();
    chk("wrap_up_end", {15'd0, wrap_a}, 16'h0000);
    repeat (3) cyc();
    chk("wrap_dn_cnt", count_a, 16'h9999);
    chk("wrap_dn_pulse", {15'd0, wrap_a}, 16'h0001);
    cyc();
    chk("wrap_dn_end", {15'd0, wrap_a}, 16'h0000);

    // Clear+load with a tick pending: clear wins, tick dropped, prescaler restarts.
    up = 1'b1;
    do_load(16'h0500);
    repeat (3) cyc();
    clear = 1'b1; load = 1'b1; load_val = 16'h1111;
    cyc();
    clear = 1'b0; load = 1'b0;
    chk("clr_count", count_a, 16'h0000);
    chk("clr_wrap", {15'd0, wrap_a}, 16'h0000);
    repeat (3) cyc();
    chk("clr_presc", count_a, 16'h0000);
    cyc();
    chk("clr_tick", count_a, 16'h0001);

    // en low mid-period: prescaler holds and resumes.
    repeat (2) cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    cyc();
    chk("hold_count", count_a, 16'h0001);
    cyc();
    chk("resume_tick", count_a, 16'h0002);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      en    = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) up = ~up;
      clear = ($urandom % 60) == 0;
      load  = ($urandom % 30) == 0;
      case ($urandom % 3)
        0:       load_val = 16'h9998;
        1:       load_val = 16'h0001;
        default: load_val = 16'($urandom);
      endcase
      cyc();
    end
    clear = 1'b0; load = 1'b0;

    // Async reset between edges.
    en = 1'b0;
    do_load(16'h1234);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_count", count_a, 16'h0000);
    chk("areset_sel", {12'd0, sel_a}, 16'h000E);
    chk("areset_code", {12'd0, code_a}, 16'h0000);
    mv = 0; mp = 0; mn = 0; mw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (12) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
